// File: rtl/alu_control_unit.sv
// Registered ALU control decoder: (ALUop, funct) -> 4-bit ALU operation select, one-cycle latency.
// Optional macro ALUCTL_ILLEGAL_TRAP_EN: illegal R-type funct registers a trap code and raises illegal.
module alu_control_unit (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] funct,
  input  logic [1:0] ALUop,
  output logic [3:0] operation,
  output logic       illegal
);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_SLL  = 4'b0100;
  localparam logic [3:0] OP_SRL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_TRAP = 4'b1111;

  localparam logic [1:0] ALUOP_MEM    = 2'b00;
  localparam logic [1:0] ALUOP_BRANCH = 2'b01;
  localparam logic [1:0] ALUOP_ORI    = 2'b10;

  logic [3:0] rtype_op;
  logic       rtype_bad;
  logic [3:0] operation_d;
  logic       illegal_d;

  // R-type funct table; rtype_bad marks the undefined codes 1001..1111.
  always_comb begin
    rtype_op  = OP_ADD;
    rtype_bad = 1'b0;
    unique case (funct)
      4'b0000: rtype_op = OP_AND;
      4'b0001: rtype_op = OP_OR;
      4'b0010: rtype_op = OP_ADD;
      4'b0011: rtype_op = OP_SUB;
      4'b0100: rtype_op = OP_SLT;
      4'b0101: rtype_op = OP_NOR;
      4'b0110: rtype_op = OP_XOR;
      4'b0111: rtype_op = OP_SLL;
      4'b1000: rtype_op = OP_SRL;
      default: rtype_bad = 1'b1;
    endcase
  end

  // funct only matters for the R-type class; the other classes are fixed ops.
  always_comb begin
    operation_d = OP_ADD;
    illegal_d   = 1'b0;
    unique case (ALUop)
      ALUOP_MEM:    operation_d = OP_ADD;
      ALUOP_BRANCH: operation_d = OP_SUB;
      ALUOP_ORI:    operation_d = OP_OR;
      default: begin
        if (rtype_bad) begin
`ifdef ALUCTL_ILLEGAL_TRAP_EN
          operation_d = OP_TRAP;
          illegal_d   = 1'b1;
`else
          // Without the trap build an undefined funct quietly behaves as ADD.
          operation_d = OP_ADD;
          illegal_d   = 1'b0;
`endif
        end else begin
          operation_d = rtype_op;
        end
      end
    endcase
  end

`ifndef ALUCTL_ILLEGAL_TRAP_EN
  logic [3:0] trap_unused;
  assign trap_unused = OP_TRAP;
`endif

  // No enable or handshake: inputs are sampled on every rising edge, reset wins.
  always_ff @(posedge clk) begin
    if (reset) begin
      operation <= OP_AND;
      illegal   <= 1'b0;
    end else begin
      operation <= operation_d;
      illegal   <= illegal_d;
    end
  end

endmodule

// File: tb/tb_alu_control_unit.sv
// Directed bench for alu_control_unit: hand-computed vectors, expected queue, one summary line.
module tb_alu_control_unit;

  logic       clk;
  logic       reset;
  logic [3:0] funct;
  logic [1:0] ALUop;
  logic [3:0] operation;
  logic       illegal;

  int checks   = 0;
  int failures = 0;

  logic [4:0] exp_q[$];
  logic [3:0] prev_op;
  logic       prev_ill;
  logic       have_prev = 1'b0;

  alu_control_unit dut (
    .clk       (clk),
    .reset     (reset),
    .funct     (funct),
    .ALUop     (ALUop),
    .operation (operation),
    .illegal   (illegal)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive one vector at the falling edge, confirm outputs have not moved yet,
  // then compare against the hand-computed result one rising edge later.
  task automatic drive_vec(input string tag, input logic rst, input logic [1:0] op,
                           input logic [3:0] fn, input logic [3:0] exp_op, input logic exp_ill);
    logic [4:0] e;
    exp_q.push_back({exp_ill, exp_op});
    @(negedge clk);
    reset = rst;
    ALUop = op;
    funct = fn;
    #1;
    if (have_prev) begin
      check({tag, "_hold_op"}, operation, prev_op);
      check({tag, "_hold_ill"}, {3'b000, illegal}, {3'b000, prev_ill});
    end
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check({tag, "_op"}, operation, e[3:0]);
    check({tag, "_ill"}, {3'b000, illegal}, {3'b000, e[4]});
    prev_op   = e[3:0];
    prev_ill  = e[4];
    have_prev = 1'b1;
  endtask

  initial begin
    reset = 1'b1;
    ALUop = 2'b11;
    funct = 4'b0001;

    // reset held for two edges with an R-type OR on the inputs
    drive_vec("rst0", 1'b1, 2'b11, 4'b0001, 4'b0000, 1'b0);
    drive_vec("rst1", 1'b1, 2'b11, 4'b0001, 4'b0000, 1'b0);
    drive_vec("rel",  1'b0, 2'b11, 4'b0001, 4'b0001, 1'b0);

    // fixed classes ignore funct
    drive_vec("mem",    1'b0, 2'b00, 4'b0001, 4'b0010, 1'b0);
    drive_vec("branch", 1'b0, 2'b01, 4'b0001, 4'b0110, 1'b0);
    drive_vec("ori",    1'b0, 2'b10, 4'b0001, 4'b0001, 1'b0);
    drive_vec("mem_f",  1'b0, 2'b00, 4'b1111, 4'b0010, 1'b0);
    drive_vec("br_f",   1'b0, 2'b01, 4'b1010, 4'b0110, 1'b0);

    // R-type sweep with a one-edge reset at funct=0101
    drive_vec("and", 1'b0, 2'b11, 4'b0000, 4'b0000, 1'b0);
    drive_vec("or",  1'b0, 2'b11, 4'b0001, 4'b0001, 1'b0);
    drive_vec("add", 1'b0, 2'b11, 4'b0010, 4'b0010, 1'b0);
    drive_vec("sub", 1'b0, 2'b11, 4'b0011, 4'b0110, 1'b0);
    drive_vec("slt", 1'b0, 2'b11, 4'b0100, 4'b0111, 1'b0);
    drive_vec("mrst", 1'b1, 2'b11, 4'b0101, 4'b0000, 1'b0);
    drive_vec("nor", 1'b0, 2'b11, 4'b0101, 4'b1100, 1'b0);
    drive_vec("xor", 1'b0, 2'b11, 4'b0110, 4'b0011, 1'b0);
    drive_vec("sll", 1'b0, 2'b11, 4'b0111, 4'b0100, 1'b0);
    drive_vec("srl", 1'b0, 2'b11, 4'b1000, 4'b0101, 1'b0);

    // undefined funct codes
`ifdef ALUCTL_ILLEGAL_TRAP_EN
    drive_vec("bad_f",   1'b0, 2'b11, 4'b1111, 4'b1111, 1'b1);
    drive_vec("bad_9",   1'b0, 2'b11, 4'b1001, 4'b1111, 1'b1);
`else
    drive_vec("bad_f",   1'b0, 2'b11, 4'b1111, 4'b0010, 1'b0);
    drive_vec("bad_9",   1'b0, 2'b11, 4'b1001, 4'b0010, 1'b0);
`endif
    drive_vec("after",   1'b0, 2'b10, 4'b1111, 4'b0001, 1'b0);
    drive_vec("nor_end", 1'b0, 2'b11, 4'b0101, 4'b1100, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_control_unit.md
Name: alu_control_unit

Overview:
- Registered ALU control decoder.
- Maps the 2-bit main-control ALU opcode and the 4-bit instruction function field to a 4-bit ALU operation select.
- Sits between the main control unit / instruction register and the ALU in the datapath.
- Output is registered on one clock with synchronous active-high reset.

Parameters:
- None. All widths are fixed: funct 4, ALUop 2, operation 4.

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- funct  input  4  instruction function field; decoded only when ALUop=11
- ALUop  input  2  ALU opcode class from main control
- operation  output  4  registered ALU operation select
- illegal  output  1  registered flag: an undefined funct was decoded with ALUop=11

Behaviour:
- Clocking: on each rising clk edge, if reset=1 then operation<=4'b0000 and illegal<=0. Otherwise both registers load the combinational decode of the current (ALUop, funct).
- Latency: exactly 1 cycle from input change to output. No enable and no handshake; inputs are sampled every cycle.
- Reset has priority over decode. Reset asserted mid-stream clears outputs at that edge. The first decode after reset release appears one edge later.
- Operation encodings: AND=0000, OR=0001, ADD=0010, XOR=0011, SLL=0100, SRL=0101, SUB=0110, SLT=0111, NOR=1100.
- Decode by ALUop (funct ignored except for 11):
  - 00: ADD (0010), for load/store address calculation.
  - 01: SUB (0110), for branch compare.
  - 10: OR (0001), for OR-immediate.
  - 11: R-type; decode funct as below.
- R-type funct decode (ALUop=11):
  - 0000 -> AND 0000
  - 0001 -> OR 0001
  - 0010 -> ADD 0010
  - 0011 -> SUB 0110
  - 0100 -> SLT 0111
  - 0101 -> NOR 1100
  - 0110 -> XOR 0011
  - 0111 -> SLL 0100
  - 1000 -> SRL 0101
  - 1001..1111 -> illegal (see Optional Feature)
- illegal is 1 only for ALUop=11 with funct in 1001..1111; otherwise 0.
- Decode is purely a function of the current inputs; no history is kept.
- X/Z on inputs is not required to be handled.

Optional Feature:
- Macro ALUCTL_ILLEGAL_TRAP_EN.
- Defined: an illegal R-type funct registers operation=4'b1111 (no-op/trap code, never a valid ALU op) and illegal=1.
- Not defined: an illegal funct falls back to ADD (0010), and illegal is held constant 0 at all times, including out of reset.
- All legal decodes are identical in both builds.

Test Plan:
- Reset: drive reset=1 for 2 edges with ALUop=11, funct=0001 -> operation=0000, illegal=0. Release reset -> after next edge operation=0001.
- Fixed classes: funct=0001 with ALUop=00 -> 0010; ALUop=01 -> 0110; ALUop=10 -> 0001. Each appears exactly one edge after the input changes.
- R-type sweep: ALUop=11, funct 0000..1000 one per cycle -> 0000, 0001, 0010, 0110, 0111, 1100, 0011, 0100, 0101, each lagging by one cycle, illegal=0.
- Illegal funct: ALUop=11, funct=1111 -> operation=1111, illegal=1 with ALUop=11, funct=1111 and ALUCTL_ILLEGAL_TRAP_EN defined; operation=0010, illegal=0 without it. Then switching to ALUop=10 -> next edge operation=0001, illegal=0.
- Mid-operation reset: during the R-type sweep, assert reset for one edge at funct=0101 -> outputs 0000/0. The next edge after release decodes the current inputs normally.
